// File: rtl/para_stat.sv
// para_stat: per-channel window statistics (max/min/sum) over N smoothed samples.
// Latency: para_* and para_vld update 1 cycle after the closing sm_vld; fx_q 1 cycle after fx_rd.
// Backpressure: none; every sm_vld is consumed, including one arriving in the latch cycle.
//
// Ports:
//   clk_sys, rst_n          clock, asynchronous active-low reset
//   sm_data, sm_vld         signed sample stream from the smoothing stage
//   fx_waddr/fx_wr/fx_data  fx bus write (addr[21:16] = device id, addr[15:0] = offset)
//   fx_raddr/fx_rd/fx_q     fx bus read; fx_q is zero unless answering a read, so slaves can be ORed
//   dev_id                  this instance's device id
//   para_max/min/sum/vld    latched result set and its one-cycle strobe
//   para_mean               (only with PARA_STAT_MEAN_EN) sum >>> floor(log2(window length))
//
// Optional feature macro: PARA_STAT_MEAN_EN (adds para_mean and registers 0x19/0x1A).
//
// Register map: 0x00 ctrl {clr, en}; 0x01 status {done, W1C}; 0x02/0x03 win_len;
// 0x10-0x17 max/min/sum; 0x18 frame_cnt; 0x19/0x1A mean (feature only).

module para_stat #(
  parameter int          DW      = 16,
  parameter int          SW      = 32,
  parameter logic [15:0] WIN_DEF = 16'd1024
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] sm_data,
  input  logic                 sm_vld,
  input  logic [21:0]          fx_waddr,
  input  logic                 fx_wr,
  input  logic [7:0]           fx_data,
  input  logic                 fx_rd,
  input  logic [21:0]          fx_raddr,
  output logic [7:0]           fx_q,
  input  logic [5:0]           dev_id,
  output logic signed [DW-1:0] para_max,
  output logic signed [DW-1:0] para_min,
  output logic signed [SW-1:0] para_sum,
  output logic                 para_vld
`ifdef PARA_STAT_MEAN_EN
  ,
  output logic signed [DW-1:0] para_mean
`endif
);

  localparam logic [15:0] OFF_CTRL    = 16'h0000;
  localparam logic [15:0] OFF_STATUS  = 16'h0001;
  localparam logic [15:0] OFF_WIN_LO  = 16'h0002;
  localparam logic [15:0] OFF_WIN_HI  = 16'h0003;
  localparam logic [15:0] OFF_MAX_LO  = 16'h0010;
  localparam logic [15:0] OFF_MAX_HI  = 16'h0011;
  localparam logic [15:0] OFF_MIN_LO  = 16'h0012;
  localparam logic [15:0] OFF_MIN_HI  = 16'h0013;
  localparam logic [15:0] OFF_SUM_B0  = 16'h0014;
  localparam logic [15:0] OFF_SUM_B1  = 16'h0015;
  localparam logic [15:0] OFF_SUM_B2  = 16'h0016;
  localparam logic [15:0] OFF_SUM_B3  = 16'h0017;
  localparam logic [15:0] OFF_FRAME   = 16'h0018;
`ifdef PARA_STAT_MEAN_EN
  localparam logic [15:0] OFF_MEAN_LO = 16'h0019;
  localparam logic [15:0] OFF_MEAN_HI = 16'h001A;
`endif

  typedef enum logic [1:0] {IDLE, ACC, LATCH} state_t;

  state_t               state;
  logic                 en;
  logic                 done;
  logic [15:0]          win_len;
  logic [15:0]          win_cur;   // window length frozen at window start
  logic [7:0]           frame_cnt;
  logic [15:0]          acc_cnt;
  logic signed [DW-1:0] acc_max;
  logic signed [DW-1:0] acc_min;
  logic signed [SW-1:0] acc_sum;

  // ---------------------------------------------------------------- bus decode
  logic        wr_hit;
  logic [15:0] wr_off;
  logic        clr_req;
  logic        done_w1c;

  assign wr_hit   = fx_wr && (fx_waddr[21:16] == dev_id);
  assign wr_off   = fx_waddr[15:0];
  assign clr_req  = wr_hit && (wr_off == OFF_CTRL) && fx_data[1];
  assign done_w1c = wr_hit && (wr_off == OFF_STATUS) && fx_data[0];

  // ---------------------------------------------------------- next-sample math
  logic [15:0]          win_eff;
  logic [15:0]          win_use;
  logic                 first;
  logic signed [SW-1:0] samp_ext;
  logic signed [SW-1:0] n_sum;
  logic signed [DW-1:0] n_max;
  logic signed [DW-1:0] n_min;
  logic [16:0]          n_cnt;
  logic                 hit;

  // A zero-length window would never close; run it as a single-sample window.
  assign win_eff  = (win_len == 16'd0) ? 16'd1 : win_len;
  // No window is open in IDLE/LATCH, or in ACC before its first sample.
  assign first    = (state != ACC) || (acc_cnt == 16'd0);
  assign win_use  = first ? win_eff : win_cur;
  assign samp_ext = SW'(sm_data);
  assign n_sum    = first ? samp_ext : acc_sum + samp_ext;
  assign n_max    = (first || (sm_data > acc_max)) ? sm_data : acc_max;
  assign n_min    = (first || (sm_data < acc_min)) ? sm_data : acc_min;
  assign n_cnt    = (first ? 17'd0 : {1'b0, acc_cnt}) + 17'd1;
  assign hit      = (n_cnt == {1'b0, win_use});

`ifdef PARA_STAT_MEAN_EN
  function automatic logic [3:0] floor_log2(input logic [15:0] v);
    floor_log2 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) floor_log2 = i[3:0];
    end
  endfunction

  logic signed [SW-1:0] mean_wide;
  logic signed [DW-1:0] n_mean;
  assign mean_wide = n_sum >>> floor_log2(win_use);
  assign n_mean    = mean_wide[DW-1:0];
`endif

  // ------------------------------------------------------ control + datapath
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en        <= 1'b0;
      done      <= 1'b0;
      win_len   <= WIN_DEF;
      win_cur   <= WIN_DEF;
      frame_cnt <= 8'd0;
      acc_cnt   <= 16'd0;
      acc_max   <= '0;
      acc_min   <= '0;
      acc_sum   <= '0;
      para_max  <= '0;
      para_min  <= '0;
      para_sum  <= '0;
      para_vld  <= 1'b0;
`ifdef PARA_STAT_MEAN_EN
      para_mean <= '0;
`endif
    end else begin
      para_vld <= 1'b0;

      if (wr_hit) begin
        case (wr_off)
          OFF_CTRL:   en            <= fx_data[0];
          OFF_WIN_LO: win_len[7:0]  <= fx_data;
          OFF_WIN_HI: win_len[15:8] <= fx_data;
          default: ;
        endcase
      end
      if (done_w1c) done <= 1'b0;

      if (!en) begin
        // Disabled: drop any partial window, keep the last published results.
        state   <= IDLE;
        acc_cnt <= 16'd0;
        acc_max <= '0;
        acc_min <= '0;
        acc_sum <= '0;
      end else if (sm_vld) begin
        if (hit) begin
          // Closing sample is folded in and published directly; the next
          // strobe, even in the LATCH cycle, opens a fresh window.
          para_max  <= n_max;
          para_min  <= n_min;
          para_sum  <= n_sum;
`ifdef PARA_STAT_MEAN_EN
          para_mean <= n_mean;
`endif
          para_vld  <= 1'b1;
          done      <= 1'b1;       // after the W1C above, so a latch keeps done set
          frame_cnt <= frame_cnt + 8'd1;
          acc_cnt   <= 16'd0;
          acc_max   <= '0;
          acc_min   <= '0;
          acc_sum   <= '0;
          state     <= LATCH;
        end else begin
          if (first) win_cur <= win_eff;
          acc_cnt <= n_cnt[15:0];
          acc_max <= n_max;
          acc_min <= n_min;
          acc_sum <= n_sum;
          state   <= ACC;
        end
      end else begin
        state <= ACC;
      end

      // clr overrides everything above, including a coincident latch.
      if (clr_req) begin
        state     <= IDLE;
        acc_cnt   <= 16'd0;
        acc_max   <= '0;
        acc_min   <= '0;
        acc_sum   <= '0;
        para_max  <= '0;
        para_min  <= '0;
        para_sum  <= '0;
`ifdef PARA_STAT_MEAN_EN
        para_mean <= '0;
`endif
        para_vld  <= 1'b0;
        done      <= 1'b0;
        frame_cnt <= 8'd0;
      end
    end
  end

  // ------------------------------------------------------------- read path
  logic [15:0] max16;
  logic [15:0] min16;
  logic [31:0] sum32;
  logic [7:0]  rd_byte;

  assign max16 = 16'(para_max);
  assign min16 = 16'(para_min);
  assign sum32 = 32'(para_sum);

`ifdef PARA_STAT_MEAN_EN
  logic [15:0] mean16;
  assign mean16 = 16'(para_mean);
`endif

  always_comb begin
    rd_byte = 8'h00;
    case (fx_raddr[15:0])
      OFF_CTRL:    rd_byte = {7'd0, en};
      OFF_STATUS:  rd_byte = {7'd0, done};
      OFF_WIN_LO:  rd_byte = win_len[7:0];
      OFF_WIN_HI:  rd_byte = win_len[15:8];
      OFF_MAX_LO:  rd_byte = max16[7:0];
      OFF_MAX_HI:  rd_byte = max16[15:8];
      OFF_MIN_LO:  rd_byte = min16[7:0];
      OFF_MIN_HI:  rd_byte = min16[15:8];
      OFF_SUM_B0:  rd_byte = sum32[7:0];
      OFF_SUM_B1:  rd_byte = sum32[15:8];
      OFF_SUM_B2:  rd_byte = sum32[23:16];
      OFF_SUM_B3:  rd_byte = sum32[31:24];
      OFF_FRAME:   rd_byte = frame_cnt;
`ifdef PARA_STAT_MEAN_EN
      OFF_MEAN_LO: rd_byte = mean16[7:0];
      OFF_MEAN_HI: rd_byte = mean16[15:8];
`endif
      default:     rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q <= 8'h00;
    end else begin
      fx_q <= (fx_rd && (fx_raddr[21:16] == dev_id)) ? rd_byte : 8'h00;
    end
  end

endmodule

// File: tb/tb_para_stat.sv
module tb_para_stat;

  localparam logic [5:0] DEV   = 6'h15;
  localparam logic [5:0] OTHER = 6'h2A;

  logic               clk_sys = 1'b0;
  logic               rst_n;
  logic signed [15:0] sm_data;
  logic               sm_vld;
  logic [21:0]        fx_waddr;
  logic               fx_wr;
  logic [7:0]         fx_data;
  logic               fx_rd;
  logic [21:0]        fx_raddr;
  logic [7:0]         fx_q;
  logic [5:0]         dev_id;
  logic signed [15:0] para_max;
  logic signed [15:0] para_min;
  logic signed [31:0] para_sum;
  logic               para_vld;
`ifdef PARA_STAT_MEAN_EN
  logic signed [15:0] para_mean;
`endif

  int checks   = 0;
  int failures = 0;

  // Result-strobe monitor, sampled on the falling edge.
  int          vld_cnt = 0;
  logic [31:0] sums [64];

  para_stat dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .sm_data  (sm_data),
    .sm_vld   (sm_vld),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .dev_id   (dev_id),
    .para_max (para_max),
    .para_min (para_min),
    .para_sum (para_sum),
    .para_vld (para_vld)
`ifdef PARA_STAT_MEAN_EN
    ,
    .para_mean(para_mean)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (rst_n === 1'b1 && para_vld === 1'b1) begin
      sums[vld_cnt % 64] = para_sum;
      vld_cnt = vld_cnt + 1;
    end
  end

  // Inputs change 1ns after a rising edge; outputs are observed at the same point.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [15:0] off, input logic [7:0] d);
    fx_wr    = 1'b1;
    fx_waddr = {DEV, off};
    fx_data  = d;
    tick();
    fx_wr    = 1'b0;
  endtask

  task automatic rd_dev(input logic [5:0] dv, input logic [15:0] off, output logic [7:0] q);
    fx_rd    = 1'b1;
    fx_raddr = {dv, off};
    tick();
    q        = fx_q;
    fx_rd    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off, output logic [7:0] q);
    rd_dev(DEV, off, q);
  endtask

  task automatic sample(input logic signed [15:0] v);
    sm_data = v;
    sm_vld  = 1'b1;
    tick();
    sm_vld  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] q;
    int base;
    rst_n = 1'b0; sm_data = '0; sm_vld = 1'b0; fx_waddr = '0; fx_wr = 1'b0;
    fx_data = '0; fx_rd = 1'b0; fx_raddr = '0; dev_id = DEV;
    repeat (3) tick();
    checks++;
    if ({fx_q, para_vld, para_max, para_min, para_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got q=%h vld=%b max=%h min=%h sum=%h want all 0",
               fx_q, para_vld, para_max, para_min, para_sum);
    end
    rst_n = 1'b1;
    tick();
    rd(16'h0002, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL win_lo_reset: got %h want 00", q); end
    rd(16'h0003, q);
    checks++;
    if (q !== 8'h04) begin failures++; $display("FAIL win_hi_reset: got %h want 04", q); end
    tick();
    checks++;
    if (fx_q !== 8'h00) begin failures++; $display("FAIL fx_q_idle: got %h want 00", fx_q); end
    rd_dev(OTHER, 16'h0003, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL fx_q_other_dev: got %h want 00", q); end
    base = vld_cnt;
    for (int i = 1; i <= 8; i++) sample(16'(i));
    tick();
    checks++;
    if (vld_cnt !== base) begin
      failures++; $display("FAIL vld_while_disabled: got %0d pulses want 0", vld_cnt - base);
    end
  endtask

  task automatic test_window4();
    logic [7:0] q;
    wr(16'h0002, 8'h04);
    wr(16'h0003, 8'h00);
    wr(16'h0000, 8'h01);
    sample(16'sd5); sample(-16'sd3); sample(16'sd7); sample(16'sd2);
    checks++;
    if (para_vld !== 1'b1 || para_max !== 16'sd7 || para_min !== 16'hFFFD || para_sum !== 32'sd11) begin
      failures++;
      $display("FAIL window4_result: got vld=%b max=%h min=%h sum=%h want 1/0007/fffd/0000000b",
               para_vld, para_max, para_min, para_sum);
    end
    tick();
    checks++;
    if (para_vld !== 1'b0) begin failures++; $display("FAIL window4_pulse_width: got vld=%b want 0", para_vld); end
    rd(16'h0001, q);
    checks++;
    if (q !== 8'h01) begin failures++; $display("FAIL window4_done: got %h want 01", q); end
    rd(16'h0018, q);
    checks++;
    if (q !== 8'h01) begin failures++; $display("FAIL window4_frame: got %h want 01", q); end
    rd(16'h0013, q);
    checks++;
    if (q !== 8'hFF) begin failures++; $display("FAIL window4_min_hi: got %h want ff", q); end
    rd(16'h0014, q);
    checks++;
    if (q !== 8'h0B) begin failures++; $display("FAIL window4_sum_b0: got %h want 0b", q); end
    wr(16'h0001, 8'h01);
    rd(16'h0001, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL done_w1c: got %h want 00", q); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q;
    int base;
    wr(16'h0002, 8'h02);
    base = vld_cnt;
    sm_vld = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      sm_data = 16'(i);
      tick();
    end
    sm_vld = 1'b0;
    repeat (2) tick();
    checks++;
    if (vld_cnt - base !== 3) begin failures++; $display("FAIL b2b_pulses: got %0d want 3", vld_cnt - base); end
    checks++;
    if (sums[base % 64] !== 32'd3 || sums[(base + 1) % 64] !== 32'd7 || sums[(base + 2) % 64] !== 32'd11) begin
      failures++;
      $display("FAIL b2b_sums: got %0d,%0d,%0d want 3,7,11",
               sums[base % 64], sums[(base + 1) % 64], sums[(base + 2) % 64]);
    end
    rd(16'h0018, q);
    checks++;
    if (q !== 8'h04) begin failures++; $display("FAIL b2b_frame: got %h want 04", q); end
  endtask

  task automatic test_en_toggle();
    int base;
    wr(16'h0002, 8'h04);
    base = vld_cnt;
    sample(16'sd1); sample(16'sd2);
    wr(16'h0000, 8'h00);
    tick();
    checks++;
    if (para_sum !== 32'sd11) begin failures++; $display("FAIL en_off_keeps_result: got %0d want 11", para_sum); end
    wr(16'h0000, 8'h01);
    repeat (4) sample(16'sd10);
    checks++;
    if (para_vld !== 1'b1 || para_max !== 16'sd10 || para_min !== 16'sd10 || para_sum !== 32'sd40) begin
      failures++;
      $display("FAIL en_toggle_result: got vld=%b max=%0d min=%0d sum=%0d want 1/10/10/40",
               para_vld, para_max, para_min, para_sum);
    end
    tick();
    checks++;
    if (vld_cnt - base !== 1) begin failures++; $display("FAIL en_toggle_pulses: got %0d want 1", vld_cnt - base); end
  endtask

  task automatic test_clr_latch();
    logic [7:0] q;
    int base;
    base = vld_cnt;
    sample(16'sd1); sample(16'sd2); sample(16'sd3);
    sm_data = 16'sd4; sm_vld = 1'b1;
    fx_wr = 1'b1; fx_waddr = {DEV, 16'h0000}; fx_data = 8'h03;
    tick();
    sm_vld = 1'b0; fx_wr = 1'b0;
    checks++;
    if (para_vld !== 1'b0 || para_sum !== 32'sd0 || para_max !== 16'sd0) begin
      failures++;
      $display("FAIL clr_latch_outputs: got vld=%b sum=%0d max=%0d want 0/0/0", para_vld, para_sum, para_max);
    end
    tick();
    checks++;
    if (vld_cnt !== base) begin failures++; $display("FAIL clr_latch_pulses: got %0d want 0", vld_cnt - base); end
    rd(16'h0018, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL clr_frame: got %h want 00", q); end
    rd(16'h0014, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL clr_sum_b0: got %h want 00", q); end
    rd(16'h0001, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL clr_done: got %h want 00", q); end
    repeat (4) sample(16'sd2);
    checks++;
    if (para_vld !== 1'b1 || para_sum !== 32'sd8) begin
      failures++; $display("FAIL clr_fresh_window: got vld=%b sum=%0d want 1/8", para_vld, para_sum);
    end
  endtask

  task automatic test_w1c_latch();
    logic [7:0] q;
    wr(16'h0001, 8'h01);
    sample(16'sd1); sample(16'sd1); sample(16'sd1);
    sm_data = 16'sd1; sm_vld = 1'b1;
    fx_wr = 1'b1; fx_waddr = {DEV, 16'h0001}; fx_data = 8'h01;
    tick();
    sm_vld = 1'b0; fx_wr = 1'b0;
    rd(16'h0001, q);
    checks++;
    if (q !== 8'h01) begin failures++; $display("FAIL w1c_vs_latch: got %h want 01", q); end
  endtask

  task automatic test_win_zero();
    wr(16'h0002, 8'h00);
    wr(16'h0003, 8'h00);
    sample(-16'sd7);
    checks++;
    if (para_vld !== 1'b1 || para_sum !== 32'hFFFF_FFF9 || para_max !== 16'hFFF9 || para_min !== 16'hFFF9) begin
      failures++;
      $display("FAIL win_zero_first: got vld=%b sum=%h max=%h min=%h want 1/fffffff9/fff9/fff9",
               para_vld, para_sum, para_max, para_min);
    end
    sample(16'sd3);
    checks++;
    if (para_vld !== 1'b1 || para_sum !== 32'sd3) begin
      failures++; $display("FAIL win_zero_second: got vld=%b sum=%0d want 1/3", para_vld, para_sum);
    end
  endtask

  task automatic test_mean();
    logic [7:0] q;
    wr(16'h0002, 8'h04);
    sample(16'sd8); sample(16'sd8); sample(16'sd8); sample(-16'sd4);
    checks++;
    if (para_sum !== 32'sd20 || para_max !== 16'sd8 || para_min !== 16'hFFFC) begin
      failures++;
      $display("FAIL mean_window: got sum=%0d max=%h min=%h want 20/0008/fffc", para_sum, para_max, para_min);
    end
`ifdef PARA_STAT_MEAN_EN
    checks++;
    if (para_mean !== 16'sd5) begin failures++; $display("FAIL mean_port: got %0d want 5", para_mean); end
    rd(16'h0019, q);
    checks++;
    if (q !== 8'h05) begin failures++; $display("FAIL mean_lo: got %h want 05", q); end
    rd(16'h001A, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL mean_hi: got %h want 00", q); end
`else
    rd(16'h0019, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL mean_unbuilt: got %h want 00", q); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] q;
    sample(16'sd9); sample(16'sd9);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({para_vld, para_max, para_min, para_sum} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got vld=%b max=%h min=%h sum=%h want all 0",
               para_vld, para_max, para_min, para_sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rd(16'h0000, q);
    checks++;
    if (q !== 8'h00) begin failures++; $display("FAIL reset_mid_ctrl: got %h want 00", q); end
    rd(16'h0003, q);
    checks++;
    if (q !== 8'h04) begin failures++; $display("FAIL reset_mid_win_hi: got %h want 04", q); end
  endtask

  initial begin
    test_reset();
    test_window4();
    test_back_to_back();
    test_en_toggle();
    test_clr_latch();
    test_w1c_latch();
    test_win_zero();
    test_mean();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
